// File: rtl/mem_copy_engine_if.sv
// Memory port shared with the core: registered-latency read channel,
// single-cycle write channel, common funct3 size selector.
interface mem_copy_engine_if;
  logic        mem_read;
  logic [31:0] read_address;
  logic        mem_ready;
  logic [31:0] read_data;
  logic        write_mem;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [2:0]  funct3;

  modport master (
    output mem_read, read_address, write_mem, write_address, write_data, funct3,
    input  mem_ready, read_data
  );

  modport slave (
    input  mem_read, read_address, write_mem, write_address, write_data, funct3,
    output mem_ready, read_data
  );
endinterface

// File: rtl/mem_copy_engine.sv
// Element-sequential block copy engine: one read, one wait, one write per
// element, so overlapping forward copies behave like a simple byte loop.
module mem_copy_engine #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       size,
  output logic             busy,
  output logic             done,
  output logic             error,
  mem_copy_engine_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FINISH} state_t;

  state_t           state;
  logic [31:0]      src_q, dst_q, data_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       sz_q;
  logic             rd_q, wr_q;
  logic [2:0]       f3_q;
  logic             misalign;
  logic [31:0]      step;

  always_comb begin
    misalign = 1'b0;
    case (size)
      2'd1:    misalign = src_addr[0] | dst_addr[0];
      2'd2:    misalign = |{src_addr[1:0], dst_addr[1:0]};
      default: misalign = 1'b0;
    endcase
  end

  assign step = 32'd1 << sz_q;

  // Unsigned encodings only, so sub-word reads come back zero-extended.
  function automatic logic [2:0] f3_of(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b100;
      2'd1:    return 3'b101;
      default: return 3'b010;
    endcase
  endfunction

  assign bus.mem_read      = rd_q & ~reset;
  assign bus.write_mem     = wr_q & ~reset;
  assign bus.read_address  = src_q;
  assign bus.write_address = dst_q;
  assign bus.write_data    = data_q;
  assign bus.funct3        = f3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      f3_q   <= 3'b010;
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
      rem_q  <= '0;
      sz_q   <= '0;
    end else begin
      done <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (size == 2'd3 || misalign) begin
            state <= FINISH;
            error <= 1'b1;
            done  <= 1'b1;
          end else if (count == '0) begin
            state <= FINISH;
            error <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= READ;
            error <= 1'b0;
            busy  <= 1'b1;
            rd_q  <= 1'b1;
            src_q <= src_addr;
            dst_q <= dst_addr;
            rem_q <= count;
            sz_q  <= size;
            f3_q  <= f3_of(size);
          end
        end
        READ: state <= WAIT;
        WAIT: if (bus.mem_ready) begin
          data_q <= bus.read_data;
          wr_q   <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          src_q <= src_q + step;
          dst_q <= dst_q + step;
          rem_q <= rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
            f3_q  <= 3'b010;
          end else begin
            state <= READ;
            rd_q  <= 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench: a byte-loop reference predicts every write; a monitor
// pops and compares on each write strobe; a byte-addressed memory serves the bus.
module tb_mem_copy_engine;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] count;
  logic [1:0]  size;
  logic        busy, done, error;
  logic        slow;

  mem_copy_engine_if bus();

  mem_copy_engine #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .count(count), .size(size), .busy(busy),
    .done(done), .error(error), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  wr_t        exp_q[$];
  int         n_cmp = 0, n_bad = 0;

  function automatic logic [7:0] rdb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rdb_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rdb(a + 32'd3), rdb(a + 32'd2), rdb(a + 32'd1), rdb(a)};
  endfunction

  function automatic logic [31:0] rd_word_ref(input logic [31:0] a);
    return {rdb_ref(a + 32'd3), rdb_ref(a + 32'd2), rdb_ref(a + 32'd1), rdb_ref(a)};
  endfunction

  function automatic logic [31:0] load(input logic [31:0] a, input logic [2:0] f);
    case (f)
      3'b100:  return {24'h0, rdb(a)};
      3'b101:  return {16'h0, rdb(a + 32'd1), rdb(a)};
      default: return rd_word(a);
    endcase
  endfunction

  task automatic poke_w(input logic [31:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      mem[a + 32'(b)]     = w[8*b +: 8];
      ref_mem[a + 32'(b)] = w[8*b +: 8];
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: element-at-a-time copy over a byte array.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic [1:0] sz);
    int          esz;
    logic [31:0] el;
    wr_t         w;
    esz = 1 << sz;
    for (int k = 0; k < n; k++) begin
      el = '0;
      for (int b = 0; b < esz; b++) el[8*b +: 8] = rdb_ref(s + 32'(k*esz + b));
      for (int b = 0; b < esz; b++) ref_mem[d + 32'(k*esz + b)] = el[8*b +: 8];
      w.a = d + 32'(k*esz);
      w.d = el;
      w.f = (sz == 2'd0) ? 3'b100 : (sz == 2'd1) ? 3'b101 : 3'b010;
      exp_q.push_back(w);
    end
  endtask

  // Memory model: one-cycle registered read, optionally stretched.
  logic        rd_pend;
  int          rd_dly;
  logic [31:0] pend_a;
  logic [2:0]  pend_f;

  always @(posedge clk) begin
    if (reset) begin
      bus.mem_ready <= 1'b0;
      bus.read_data <= '0;
      rd_pend       <= 1'b0;
    end else begin
      bus.mem_ready <= 1'b0;
      if (rd_pend) begin
        if (rd_dly == 0) begin
          bus.mem_ready <= 1'b1;
          bus.read_data <= load(pend_a, pend_f);
          rd_pend       <= 1'b0;
        end else rd_dly <= rd_dly - 1;
      end
      if (bus.mem_read) begin
        if (!slow) begin
          bus.mem_ready <= 1'b1;
          bus.read_data <= load(bus.read_address, bus.funct3);
        end else begin
          rd_pend <= 1'b1;
          rd_dly  <= $urandom_range(0, 2);
          pend_a  <= bus.read_address;
          pend_f  <= bus.funct3;
        end
      end
      if (bus.write_mem) begin
        case (bus.funct3)
          3'b100: mem[bus.write_address] = bus.write_data[7:0];
          3'b101: for (int b = 0; b < 2; b++) mem[bus.write_address + 32'(b)] = bus.write_data[8*b +: 8];
          default: for (int b = 0; b < 4; b++) mem[bus.write_address + 32'(b)] = bus.write_data[8*b +: 8];
        endcase
      end
    end
  end

  wr_t mw;
  always @(negedge clk) begin
    if (!reset && bus.write_mem) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                 bus.write_address, bus.write_data);
      end else begin
        mw = exp_q.pop_front();
        check("wr_addr", bus.write_address, mw.a);
        check("wr_data", bus.write_data, mw.d);
        check("wr_funct3", {29'h0, bus.funct3}, {29'h0, mw.f});
      end
    end
  end

  // Issues one start from a negedge and follows it to done; an optional second
  // start pulse with different operands is fired at cycle ign_cyc.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input logic [1:0] sz, input int ign_cyc);
    logic legal, seen;
    int   c, bsy, rds, exp_cyc;
    legal = (sz != 2'd3) && !(sz == 2'd1 && (s[0] || d[0])) &&
            !(sz == 2'd2 && (s[1:0] != 2'b00 || d[1:0] != 2'b00));
    if (legal) model_copy(s, d, n, sz);
    start = 1'b1; src_addr = s; dst_addr = d; count = 16'(n); size = sz;
    seen = 1'b0; bsy = 0; rds = 0;
    for (c = 1; c <= 8*n + 12; c++) begin
      @(negedge clk);
      start = (c == ign_cyc);
      if (c == ign_cyc) begin
        src_addr = 32'h0000_0800; dst_addr = 32'h0000_0900; count = 16'd1; size = 2'd2;
      end
      bsy += int'(busy);
      rds += int'(bus.mem_read);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    exp_cyc = (legal && n != 0) ? 3*n + 1 : 1;
    check("done_seen", 32'(seen), 32'd1);
    if (!slow) check("done_cycle", 32'(c), 32'(exp_cyc));
    check("error", 32'(error), 32'(!legal));
    check("read_count", 32'(rds), legal ? 32'(n) : 32'd0);
    if (!slow) check("busy_cycles", 32'(bsy), legal ? 32'(3*n) : 32'd0);
    check("writes_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic        dn;
    logic [1:0]  sz;
    logic [31:0] s, d;
    int          esz, n, r;
    slow = 1'b0; reset = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; count = '0; size = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_write_mem", 32'(bus.write_mem), 32'd0);
    check("rst_funct3", {29'h0, bus.funct3}, 32'd2);
    check("rst_rd_addr", bus.read_address, 32'd0);
    check("rst_wr_data", bus.write_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Word copy
    poke_w(32'h100, 32'h1111_1111); poke_w(32'h104, 32'h8000_0002);
    poke_w(32'h108, 32'hDEAD_BEEF); poke_w(32'h10C, 32'h0000_0004);
    run_copy(32'h100, 32'h200, 4, 2'd2, 0);
    check("word0", rd_word(32'h200), 32'h1111_1111);
    check("word1", rd_word(32'h204), 32'h8000_0002);
    check("word2", rd_word(32'h208), 32'hDEAD_BEEF);
    check("word3", rd_word(32'h20C), 32'h0000_0004);

    // Byte copy must leave the untouched low byte alone
    poke_w(32'h100, 32'h7FFF_8011);
    poke_w(32'h300, 32'hAAAA_AAAA);
    run_copy(32'h101, 32'h301, 3, 2'd0, 0);
    check("byte_merge", rd_word(32'h300), 32'h7FFF_80AA);

    // Misaligned half, sticky error, then cleared by a good start
    run_copy(32'h102, 32'h203, 2, 2'd1, 0);
    repeat (2) @(negedge clk);
    check("error_sticky", 32'(error), 32'd1);
    run_copy(32'h200, 32'h500, 2, 2'd1, 0);

    // Zero count and illegal size
    run_copy(32'h100, 32'h200, 0, 2'd2, 0);
    run_copy(32'h100, 32'h200, 1, 2'd3, 0);

    // Reset during the second element's wait
    poke_w(32'h100, 32'h1111_1111); poke_w(32'h104, 32'h8000_0002);
    poke_w(32'h400, 32'h0); poke_w(32'h404, 32'h5555_5555);
    model_copy(32'h100, 32'h400, 1, 2'd2);
    start = 1'b1; src_addr = 32'h100; dst_addr = 32'h400; count = 16'd4; size = 2'd2;
    dn = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dn = 1'b1;
      if (c == 5) reset = 1'b1;
      if (c == 6) begin
        check("busy_after_reset", 32'(busy), 32'd0);
        reset = 1'b0;
      end
    end
    check("no_done_after_reset", 32'(dn), 32'd0);
    check("reset_writes_pending", 32'(exp_q.size()), 32'd0);
    check("reset_first_word", rd_word(32'h400), 32'h1111_1111);
    check("reset_second_word", rd_word(32'h404), 32'h5555_5555);

    // Start during busy is ignored
    run_copy(32'h100, 32'h600, 3, 2'd2, 4);

    // Peripheral at the top of the address space, then wrap to 0
    poke_w(32'h0, 32'h4030_2010); poke_w(32'h4, 32'hCAFE_F00D);
    run_copy(32'h0, 32'hFFFF_FFFC, 1, 2'd2, 0);
    check("led_reg", rd_word(32'hFFFF_FFFC), 32'h4030_2010);
    run_copy(32'h0, 32'hFFFF_FFFC, 2, 2'd2, 0);
    check("wrap_word", rd_word(32'h0), 32'hCAFE_F00D);

    // Random copies in a small overlapping window, with stretched reads
    for (int a = 0; a < 64; a += 4) poke_w(32'h1000 + 32'(a), $urandom);
    for (int it = 0; it < 24; it++) begin
      r  = $urandom_range(0, 9);
      sz = (r == 9) ? 2'd3 : 2'(r % 3);
      esz = (sz == 2'd3) ? 4 : (1 << sz);
      s = 32'h1000 + 32'($urandom_range(0, 31));
      d = 32'h1000 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 4) != 0) s = s & ~32'(esz - 1);
      if ($urandom_range(0, 4) != 0) d = d & ~32'(esz - 1);
      n = $urandom_range(0, 6);
      slow = 1'($urandom_range(0, 1));
      run_copy(s, d, n, sz, 0);
    end
    slow = 1'b0;
    for (int a = 0; a < 64; a += 4)
      check("region", rd_word(32'h1000 + 32'(a)), rd_word_ref(32'h1000 + 32'(a)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-initiator block that drives the processor-side memory port (read channel with one-cycle registered read latency and `mem_ready`, single-cycle write channel, shared `funct3` size/sign selector) to copy a block of bytes, half-words or words from a source to a destination address. It sits beside the core as a second initiator on the same memory port and is muxed in by the top level while `busy` is high. Software-style control is a start pulse plus source, destination, count and size; completion is a one-cycle `done` pulse with a sticky `error` flag.

## Interface
- `CNT_W`, 16, width of the transfer count.
- `clk` input 1: system clock, all state on posedge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a copy; sampled only in IDLE.
- `src_addr` input 32: first source byte address, sampled with `start`.
- `dst_addr` input 32: first destination byte address, sampled with `start`.
- `count` input CNT_W: number of transfers (elements), sampled with `start`.
- `size` input 2: 0 = byte, 1 = half-word, 2 = word, 3 = illegal.
- `busy` output 1: copy in progress.
- `done` output 1: one-cycle completion pulse.
- `error` output 1: last request rejected; sticky until next accepted `start` or `reset`.
- `mem_read` output 1: read request to memory.
- `read_address` output 32: read byte address.
- `mem_ready` input 1: read data valid, one cycle after `mem_read`.
- `read_data` input 32: zero-extended read data.
- `write_mem` output 1: write strobe, committed at the next posedge.
- `write_address` output 32: write byte address.
- `write_data` output 32: write data, element in the low bits.
- `funct3` output 3: access size: byte 3'b100, half 3'b101, word 3'b010; 3'b010 when idle.

## Operation
- States: IDLE, READ, WAIT, WRITE, FINISH.
- IDLE:
  - `start` with size 3, or with an address misaligned for the size (half: bit 0 set; word: bits 1:0 nonzero, on src or dst), goes to FINISH with `error` = 1. No memory access occurs.
  - `start` with `count` = 0 goes to FINISH with `error` = 0. No access occurs.
  - Otherwise the block latches the addresses, count and size, clears `error`, and goes to READ.
- READ: `mem_read` = 1, `read_address` = current src. Always goes to WAIT.
- WAIT: `mem_read` = 0. If `mem_ready`, latch `read_data` into the data register and go to WRITE; else stay.
- WRITE:
  - `write_mem` = 1, `write_address` = current dst, `write_data` = data register.
  - Advance src and dst by 1, 2 or 4 (mod 2^32, wrap allowed) and decrement the remaining count.
  - Go to READ if the remaining count is nonzero after decrement, else go to FINISH.
- FINISH: `done` = 1 for one cycle, then IDLE.
- `funct3` is constant from READ of the first element through the last WRITE.
- Element-sequential semantics: each write commits before the next read, so overlapping forward copies propagate, as a byte-at-a-time loop would.
- `start` outside IDLE is ignored. Input changes while busy have no effect.
- Unsigned `funct3` encodings guarantee zero-extension, so sub-word neighbours in the destination word are never disturbed.

## Timing
- Reset values: state IDLE; `busy`, `done`, `error`, `mem_read`, `write_mem` = 0; `funct3` = 3'b010; addresses and data = 0.
- `mem_read` and `write_mem` are gated by `!reset`, so no access issues during a reset cycle.
- Reset mid-copy: returns to IDLE at the next edge. Writes already committed stay; no `done` pulse.
- `start` high in cycle 0 (IDLE):
  - First READ is in cycle 1.
  - Element k (0-based) is READ in cycle 3k+1, WAIT (with `mem_ready` = 1 on this memory) in cycle 3k+2, WRITE in cycle 3k+3.
  - `done` is in cycle 3N+1. `busy` is high in cycles 1..3N.
- Rejected or zero-count start: `done` in cycle 1, `busy` never asserts.
- `mem_ready` latency longer than one cycle only extends WAIT; correctness is unaffected.

## Test plan
- Word copy: mem[0x100..0x10C] = 0x11111111, 0x80000002, 0xDEADBEEF, 0x00000004; start(src 0x100, dst 0x200, count 4, size 2) -> identical words at 0x200..0x20C; `done` in cycle 13; exactly 4 `write_mem` pulses.
- Byte copy, no sign spill: src bytes 0x80, 0xFF, 0x7F at 0x101; dst word 0x300 preset 0xAAAAAAAA; start(0x101, 0x301, 3, 0) -> mem[0x300] = 0x7FFF80AA.
- Misaligned half: start(0x102, 0x203, 2, 1) -> `error` = 1, `done` in cycle 1; `mem_read` and `write_mem` never assert. A following valid start clears `error`.
- Count 0 and illegal size 3 -> `done` next cycle; `error` = 0 and 1 respectively; no bus activity.
- Reset in cycle 5 of a count-4 word copy -> first word written, second not; `busy` = 0 next cycle; no `done`. `start` asserted during busy is ignored (write count unchanged).
- Peripheral copy: word 0x40302010 at 0x0 copied to 0xFFFFFFFC -> LED register reads back 0x40302010. dst 0xFFFFFFFC with count 2 -> second write goes to 0x00000000 (wrap).
